peripheral_system_n: RTL and testbench

Parametrised dual-port communication peripheral between the processor core and the external control system. It provides NUM_REGS shared 32-bit registers, the control/metric/phase registers with self-clearing pulse bits, NUM_CACHE read-only cache status words, and a core-to-control-system mailbox FIFO with status and overflow tracking. Both bus ports are registered with single-cycle read latency. The block sits on the peripheral bus beside the cache controllers.

---
 rtl/peripheral_system_n.sv | 142 ++++++++++++++
 tb/tb_peripheral_system_n.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_system_n.sv
// Dual-port core / control-system peripheral: shared registers, pulse-bit control
// registers, cache status window and a core-to-control-system mailbox FIFO.
module peripheral_system_n #(
  parameter int NUM_REGS   = 4,
  parameter int NUM_CACHE  = 2,
  parameter int MBOX_DEPTH = 8
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    req_core_i,
  input  logic                    rw_core_i,
  input  logic [26:0]             add_core_i,
  input  logic [31:0]             data_core_i,
  output logic [31:0]             data_core_o,
  input  logic                    req_cs_i,
  input  logic                    rw_cs_i,
  input  logic [26:0]             add_cs_i,
  input  logic [31:0]             data_cs_i,
  output logic [31:0]             data_cs_o,
  input  logic [32*NUM_CACHE-1:0] comm_cache_i,
  output logic [1:0]              metric_sel_o,
  output logic [31:0]             phase_o,
  output logic [31:0]             comm_o,
  output logic                    mbox_irq_o
);

  localparam int         PTR_W      = (MBOX_DEPTH > 1) ? $clog2(MBOX_DEPTH) : 1;
  localparam logic [7:0] DEPTH_CNT  = 8'(MBOX_DEPTH);
  localparam logic [7:0] OFF_CTRL   = 8'h40;
  localparam logic [7:0] OFF_METRIC = 8'h41;
  localparam logic [7:0] OFF_PHASE  = 8'h42;
  localparam logic [7:0] OFF_CACHE  = 8'h50;
  localparam logic [7:0] OFF_MDATA  = 8'h60;
  localparam logic [7:0] OFF_MSTAT  = 8'h61;
  localparam logic [31:0] RD_IDLE   = 32'hDEADBEAF;

  logic [31:0]      gen_q [NUM_REGS];
  logic [7:0]       comm_pro_q;
  logic [23:0]      comm_cs_q;
  logic [1:0]       metric_q;
  logic [31:0]      phase_q;
  logic [31:0]      mbox_mem [MBOX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [7:0]       count_q;
  logic             overflow_q;

  logic [7:0]  core_off, cs_off;
  logic        core_wr, core_rd, cs_wr, cs_rd;
  logic        push, pop, stat_rd, pop_ok, push_ok, push_drop;
  logic [31:0] core_rdata_p0, cs_rdata_p0;
  logic        unused_addr_bits;

  assign core_off = add_core_i[7:0];
  assign cs_off   = add_cs_i[7:0];
  assign unused_addr_bits = ^{add_core_i[26:8], add_cs_i[26:8]};

  assign core_wr = req_core_i &  rw_core_i;
  assign core_rd = req_core_i & ~rw_core_i;
  assign cs_wr   = req_cs_i   &  rw_cs_i;
  assign cs_rd   = req_cs_i   & ~rw_cs_i;

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push      = core_wr & (core_off == OFF_MDATA);
  assign pop       = cs_rd   & (cs_off == OFF_MDATA);
  assign stat_rd   = cs_rd   & (cs_off == OFF_MSTAT);
  assign pop_ok    = pop & (count_q != 8'd0);
  assign push_ok   = push & ((count_q != DEPTH_CNT) | pop_ok);
  assign push_drop = push & ~push_ok;

  assign comm_o       = {comm_pro_q, comm_cs_q};
  assign phase_o      = phase_q;
  assign metric_sel_o = metric_q;
  assign mbox_irq_o   = (count_q != 8'd0);

  always_comb begin
    core_rdata_p0 = 32'd0;
    for (int i = 0; i < NUM_REGS; i++)
      if (core_off == 8'(i)) core_rdata_p0 = gen_q[i];
    if (core_off == OFF_CTRL)  core_rdata_p0 = comm_o;
    if (core_off == OFF_PHASE) core_rdata_p0 = phase_q;
  end

  always_comb begin
    cs_rdata_p0 = 32'd0;
    for (int i = 0; i < NUM_REGS; i++)
      if (cs_off == 8'(i)) cs_rdata_p0 = gen_q[i];
    for (int k = 0; k < NUM_CACHE; k++)
      if (cs_off == OFF_CACHE + 8'(k)) cs_rdata_p0 = comm_cache_i[32*k +: 32];
    if (cs_off == OFF_CTRL)   cs_rdata_p0 = comm_o;
    if (cs_off == OFF_METRIC) cs_rdata_p0 = {30'd0, metric_q};
    if (cs_off == OFF_MDATA)  cs_rdata_p0 = pop_ok ? mbox_mem[rd_ptr_q] : 32'd0;
    if (cs_off == OFF_MSTAT)  cs_rdata_p0 = {overflow_q, 23'd0, count_q};
  end

  // Registered state; read data is captured from the pre-edge state
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) gen_q[i] <= 32'd0;
      comm_pro_q  <= 8'd0;
      comm_cs_q   <= 24'd0;
      metric_q    <= 2'd0;
      phase_q     <= 32'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 8'd0;
      overflow_q  <= 1'b0;
      data_core_o <= RD_IDLE;
      data_cs_o   <= RD_IDLE;
    end else begin
      // Core write is applied last so it wins a same-index collision.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (cs_wr && cs_off == 8'(i))     gen_q[i] <= data_cs_i;
        if (core_wr && core_off == 8'(i)) gen_q[i] <= data_core_i;
      end
      if (cs_wr && cs_off == OFF_CTRL) comm_cs_q <= data_cs_i[23:0];
      else                             comm_cs_q[23] <= 1'b0;
      if (core_wr && core_off == OFF_CTRL) comm_pro_q <= data_core_i[7:0];
      if (cs_wr && cs_off == OFF_METRIC)   metric_q <= data_cs_i[1:0];
      if (core_wr && core_off == OFF_PHASE) phase_q <= {1'b1, data_core_i[30:0]};
      else                                  phase_q[31] <= 1'b0;

      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 8'd1;
        2'b01:   count_q <= count_q - 8'd1;
        default: count_q <= count_q;
      endcase
      if (push_drop)    overflow_q <= 1'b1;
      else if (stat_rd) overflow_q <= 1'b0;

      if (core_rd) data_core_o <= core_rdata_p0;
      if (cs_rd)   data_cs_o   <= cs_rdata_p0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_ok) mbox_mem[wr_ptr_q] <= data_core_i;
  end

endmodule

// File: tb/tb_peripheral_system_n.sv
// Bench for peripheral_system_n: directed scenarios plus random traffic against
// a queue-based reference model of the register map and mailbox.
module tb_peripheral_system_n;

  localparam int NUM_REGS   = 4;
  localparam int NUM_CACHE  = 2;
  localparam int MBOX_DEPTH = 8;

  logic                    clock_i = 1'b0;
  logic                    reset_i = 1'b1;
  logic                    req_core_i = 1'b0, rw_core_i = 1'b0;
  logic [26:0]             add_core_i = '0;
  logic [31:0]             data_core_i = '0;
  logic [31:0]             data_core_o;
  logic                    req_cs_i = 1'b0, rw_cs_i = 1'b0;
  logic [26:0]             add_cs_i = '0;
  logic [31:0]             data_cs_i = '0;
  logic [31:0]             data_cs_o;
  logic [32*NUM_CACHE-1:0] comm_cache_i = '0;
  logic [1:0]              metric_sel_o;
  logic [31:0]             phase_o;
  logic [31:0]             comm_o;
  logic                    mbox_irq_o;

  peripheral_system_n #(.NUM_REGS(NUM_REGS), .NUM_CACHE(NUM_CACHE), .MBOX_DEPTH(MBOX_DEPTH)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .req_core_i(req_core_i), .rw_core_i(rw_core_i), .add_core_i(add_core_i),
    .data_core_i(data_core_i), .data_core_o(data_core_o),
    .req_cs_i(req_cs_i), .rw_cs_i(rw_cs_i), .add_cs_i(add_cs_i),
    .data_cs_i(data_cs_i), .data_cs_o(data_cs_o),
    .comm_cache_i(comm_cache_i), .metric_sel_o(metric_sel_o), .phase_o(phase_o),
    .comm_o(comm_o), .mbox_irq_o(mbox_irq_o)
  );

  always #5 clock_i = ~clock_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_gen [NUM_REGS];
  logic [7:0]  m_pro;
  logic [23:0] m_cs;
  logic [1:0]  m_metric;
  logic [31:0] m_phase;
  logic [31:0] m_q [$];
  logic        m_ovf;
  logic [31:0] m_core_o, m_cs_o;

  task automatic model_step(input logic rst, input logic rqc, input logic rwc, input logic [7:0] ac,
                            input logic [31:0] dc, input logic rqs, input logic rws,
                            input logic [7:0] as, input logic [31:0] ds);
    int unsigned oc, os;
    bit pushed;
    oc = ac; os = as;
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) m_gen[i] = 0;
      m_pro = 0; m_cs = 0; m_metric = 0; m_phase = 0; m_ovf = 0;
      m_q.delete();
      m_core_o = 32'hDEADBEAF; m_cs_o = 32'hDEADBEAF;
      return;
    end
    // reads see the state before this edge
    if (rqc && !rwc) begin
      if (oc < NUM_REGS)   m_core_o = m_gen[oc];
      else if (oc == 'h40) m_core_o = {m_pro, m_cs};
      else if (oc == 'h42) m_core_o = m_phase;
      else                 m_core_o = 0;
    end
    if (rqs && !rws) begin
      if (os < NUM_REGS)                          m_cs_o = m_gen[os];
      else if (os == 'h40)                        m_cs_o = {m_pro, m_cs};
      else if (os == 'h41)                        m_cs_o = {30'd0, m_metric};
      else if (os >= 'h50 && os < 'h50+NUM_CACHE) m_cs_o = comm_cache_i[32*(os-'h50) +: 32];
      else if (os == 'h61)                        m_cs_o = {m_ovf, 23'd0, 8'(m_q.size())};
      else if (os == 'h60)                        m_cs_o = (m_q.size() > 0) ? m_q.pop_front() : 32'd0;
      else                                        m_cs_o = 0;
    end
    pushed = 0;
    if (rqc && rwc && oc == 'h60) begin
      if (m_q.size() < MBOX_DEPTH) m_q.push_back(dc);
      else pushed = 1;
    end
    if (rqs && !rws && os == 'h61) m_ovf = 0;
    if (pushed) m_ovf = 1;
    if (rqs && rws && os < NUM_REGS) m_gen[os] = ds;
    if (rqc && rwc && oc < NUM_REGS) m_gen[oc] = dc;
    if (rqs && rws && os == 'h40) m_cs = ds[23:0]; else m_cs[23] = 1'b0;
    if (rqc && rwc && oc == 'h40) m_pro = dc[7:0];
    if (rqs && rws && os == 'h41) m_metric = ds[1:0];
    if (rqc && rwc && oc == 'h42) m_phase = {1'b1, dc[30:0]}; else m_phase[31] = 1'b0;
  endtask

  task automatic step(input logic rst, input logic rqc, input logic rwc, input logic [7:0] ac,
                      input logic [31:0] dc, input logic rqs, input logic rws,
                      input logic [7:0] as, input logic [31:0] ds);
    reset_i = rst;
    req_core_i = rqc; rw_core_i = rwc; add_core_i = {19'($urandom), ac}; data_core_i = dc;
    req_cs_i = rqs; rw_cs_i = rws; add_cs_i = {19'($urandom), as}; data_cs_i = ds;
    @(posedge clock_i);
    model_step(rst, rqc, rwc, ac, dc, rqs, rws, as, ds);
    #1;
    check("data_core_o", data_core_o, m_core_o);
    check("data_cs_o", data_cs_o, m_cs_o);
    check("comm_o", comm_o, {m_pro, m_cs});
    check("phase_o", phase_o, m_phase);
    check("metric_sel_o", 32'(metric_sel_o), 32'(m_metric));
    check("mbox_irq_o", 32'(mbox_irq_o), 32'(m_q.size() != 0));
  endtask

  task automatic idle();                                      step(0, 0,0,8'h00,0, 0,0,8'h00,0); endtask
  task automatic core_write(input logic [7:0] a, input logic [31:0] d); step(0, 1,1,a,d, 0,0,8'h00,0); endtask
  task automatic cs_write(input logic [7:0] a, input logic [31:0] d);   step(0, 0,0,8'h00,0, 1,1,a,d); endtask
  task automatic cs_read(input logic [7:0] a);                step(0, 0,0,8'h00,0, 1,0,a,0); endtask

  function automatic logic [7:0] pick_off();
    logic [7:0] offs [14];
    offs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h40, 8'h41, 8'h42,
             8'h50, 8'h51, 8'h52, 8'h60, 8'h61, 8'h7F};
    if ($urandom_range(0, 2) == 0) return ($urandom_range(0, 1) == 0) ? 8'h60 : 8'h61;
    return offs[$urandom_range(0, 13)];
  endfunction

  initial begin
    // reset
    step(1, 0,0,8'h00,0, 0,0,8'h00,0);
    step(1, 0,0,8'h00,0, 0,0,8'h00,0);
    check("rst_core_o", data_core_o, 32'hDEADBEAF);
    check("rst_cs_o", data_cs_o, 32'hDEADBEAF);
    check("rst_comm_o", comm_o, 32'h0);
    check("rst_phase_o", phase_o, 32'h0);
    check("rst_irq", 32'(mbox_irq_o), 32'h0);

    // GEN collision: core wins
    step(0, 1,1,8'h02,32'h12345678, 1,1,8'h02,32'hAAAA5555);
    cs_read(8'h02);
    check("gen_collision", data_cs_o, 32'h12345678);

    // pulse bits
    cs_write(8'h40, 32'h00FFFFFF);
    check("ctrl_pulse_set", comm_o, 32'h00FFFFFF);
    idle();
    check("ctrl_pulse_clr", comm_o, 32'h007FFFFF);
    idle();
    check("ctrl_pulse_hold", comm_o, 32'h007FFFFF);
    core_write(8'h42, 32'h5);
    check("phase_pulse_set", phase_o, 32'h80000005);
    idle();
    check("phase_pulse_clr", phase_o, 32'h00000005);

    // mailbox overflow and drain
    for (int i = 1; i <= 9; i++) core_write(8'h60, 32'(i));
    cs_read(8'h61);
    check("mstat_ovf", data_cs_o, 32'h80000008);
    cs_read(8'h61);
    check("mstat_clr", data_cs_o, 32'h00000008);
    for (int i = 1; i <= 8; i++) begin
      cs_read(8'h60);
      check("pop_data", data_cs_o, 32'(i));
      check("pop_irq", 32'(mbox_irq_o), (i < 8) ? 32'd1 : 32'd0);
    end
    cs_read(8'h60);
    check("pop_empty", data_cs_o, 32'h0);

    // simultaneous push + pop
    core_write(8'h60, 32'hA);
    step(0, 1,1,8'h60,32'hB, 1,0,8'h60,0);
    check("pushpop_head", data_cs_o, 32'hA);
    cs_read(8'h61);
    check("pushpop_cnt", data_cs_o, 32'h1);
    cs_read(8'h60);
    check("pushpop_new", data_cs_o, 32'hB);
    step(0, 1,1,8'h60,32'hC, 1,0,8'h60,0);
    check("pushpop_empty", data_cs_o, 32'h0);
    cs_read(8'h61);
    check("pushpop_empty_cnt", data_cs_o, 32'h1);
    cs_read(8'h60);
    check("pushpop_c", data_cs_o, 32'hC);

    // full + push + pop: no overflow
    for (int i = 0; i < 8; i++) core_write(8'h60, 32'h100 + 32'(i));
    step(0, 1,1,8'h60,32'h1FF, 1,0,8'h60,0);
    check("full_pushpop", data_cs_o, 32'h100);
    cs_read(8'h61);
    check("full_pushpop_stat", data_cs_o, 32'h00000008);

    // cache window
    comm_cache_i = {32'hCAFE0001, 32'hBEEF0000};
    cs_read(8'h50);
    check("cache0", data_cs_o, 32'hBEEF0000);
    cs_read(8'h51);
    check("cache1", data_cs_o, 32'hCAFE0001);
    cs_read(8'h52);
    check("cache_unmapped", data_cs_o, 32'h0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) comm_cache_i = {$urandom, $urandom};
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), pick_off(), $urandom,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), pick_off(), $urandom);
    end

    // reset with mailbox contents discards them
    for (int i = 0; i < 3; i++) core_write(8'h60, 32'h55 + 32'(i));
    step(1, 0,0,8'h00,0, 0,0,8'h00,0);
    check("midrst_irq", 32'(mbox_irq_o), 32'h0);
    cs_read(8'h61);
    check("midrst_stat", data_cs_o, 32'h0);
    cs_read(8'h60);
    check("midrst_pop", data_cs_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
